// File: rtl/mem_access_ctrl_if.sv
// Data-memory request/acknowledge bus between the memory-access stage (master)
// and the data memory (slave).
interface mem_access_ctrl_if #(
   parameter int n = 32
);
   logic         dmem_req;
   logic         dmem_we;
   logic [n-1:0] dmem_addr;
   logic [n-1:0] dmem_wdata;
   logic         dmem_ack;
   logic [n-1:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_ack, dmem_rdata
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-access pipeline stage: issues a held dmem request for aligned loads/stores,
// stalls upstream while it is outstanding and produces the MEM/WB results.
module mem_access_ctrl #(
   parameter int n       = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset_in,
   input  logic              RegWrite_in,
   input  logic              MemtoReg_in,
   input  logic              MemRead_in,
   input  logic              MemWrite_in,
   input  logic [n-1:0]      ALU_Result_in,
   input  logic [n-1:0]      RT_data_in,
   input  logic [4:0]        Write_Reg_in,
   mem_access_ctrl_if.master mem,
   output logic              stall_out,
   output logic              RegWrite_out,
   output logic              MemtoReg_out,
   output logic [n-1:0]      Read_Data_out,
   output logic [n-1:0]      ALU_Result_out,
   output logic [4:0]        Write_Reg_out,
   output logic              misalign_out,
   output logic              bus_err_out
);
   typedef enum logic {IDLE, ACCESS} state_t;

   localparam int CW = $clog2(TIMEOUT + 1);

   state_t        state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic          req_reg, req_next;
   logic          we_reg, we_next;
   logic [n-1:0]  addr_reg, addr_next;
   logic [n-1:0]  wdata_reg, wdata_next;
   logic          cap_rw_reg, cap_rw_next;
   logic          cap_m2r_reg, cap_m2r_next;
   logic [4:0]    cap_wr_reg, cap_wr_next;
   logic          rw_reg, rw_next;
   logic          m2r_reg, m2r_next;
   logic [n-1:0]  rd_reg, rd_next;
   logic [n-1:0]  alu_reg, alu_next;
   logic [4:0]    wr_reg, wr_next;
   logic          mis_reg, mis_next;
   logic          berr_reg, berr_next;
   logic          is_mem;

   assign is_mem = MemRead_in | MemWrite_in;

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      req_next     = req_reg;
      we_next      = we_reg;
      addr_next    = addr_reg;
      wdata_next   = wdata_reg;
      cap_rw_next  = cap_rw_reg;
      cap_m2r_next = cap_m2r_reg;
      cap_wr_next  = cap_wr_reg;
      rw_next      = rw_reg;
      m2r_next     = m2r_reg;
      rd_next      = rd_reg;
      alu_next     = alu_reg;
      wr_next      = wr_reg;
      mis_next     = 1'b0;
      berr_next    = 1'b0;

      case (state_reg)
         IDLE: begin
            if (!is_mem) begin
               rw_next  = RegWrite_in;
               m2r_next = MemtoReg_in;
               alu_next = ALU_Result_in;
               wr_next  = Write_Reg_in;
               rd_next  = '0;
            end else if (ALU_Result_in[1:0] != 2'b00) begin
               mis_next = 1'b1;
               rw_next  = 1'b0;
            end else begin
               // A write bit wins over a read bit, so "both set" becomes a store.
               state_next   = ACCESS;
               cnt_next     = '0;
               req_next     = 1'b1;
               we_next      = MemWrite_in;
               addr_next    = ALU_Result_in;
               wdata_next   = RT_data_in;
               cap_rw_next  = RegWrite_in;
               cap_m2r_next = MemtoReg_in;
               cap_wr_next  = Write_Reg_in;
               rw_next      = 1'b0;
            end
         end
         ACCESS: begin
            // Ack is tested first so it wins over a timeout on the same edge.
            if (mem.dmem_ack) begin
               state_next = IDLE;
               req_next   = 1'b0;
               rw_next    = cap_rw_reg;
               m2r_next   = cap_m2r_reg;
               alu_next   = addr_reg;
               wr_next    = cap_wr_reg;
               rd_next    = we_reg ? '0 : mem.dmem_rdata;
            end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
               state_next = IDLE;
               cnt_next   = CW'(TIMEOUT);
               req_next   = 1'b0;
               berr_next  = 1'b1;
               rw_next    = 1'b0;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_in) begin
      if (!reset_in) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         req_reg     <= 1'b0;
         we_reg      <= 1'b0;
         addr_reg    <= '0;
         wdata_reg   <= '0;
         cap_rw_reg  <= 1'b0;
         cap_m2r_reg <= 1'b0;
         cap_wr_reg  <= '0;
         rw_reg      <= 1'b0;
         m2r_reg     <= 1'b0;
         rd_reg      <= '0;
         alu_reg     <= '0;
         wr_reg      <= '0;
         mis_reg     <= 1'b0;
         berr_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         req_reg     <= req_next;
         we_reg      <= we_next;
         addr_reg    <= addr_next;
         wdata_reg   <= wdata_next;
         cap_rw_reg  <= cap_rw_next;
         cap_m2r_reg <= cap_m2r_next;
         cap_wr_reg  <= cap_wr_next;
         rw_reg      <= rw_next;
         m2r_reg     <= m2r_next;
         rd_reg      <= rd_next;
         alu_reg     <= alu_next;
         wr_reg      <= wr_next;
         mis_reg     <= mis_next;
         berr_reg    <= berr_next;
      end
   end

   assign stall_out      = (state_reg == ACCESS);
   assign mem.dmem_req   = req_reg;
   assign mem.dmem_we    = we_reg;
   assign mem.dmem_addr  = addr_reg;
   assign mem.dmem_wdata = wdata_reg;
   assign RegWrite_out   = rw_reg;
   assign MemtoReg_out   = m2r_reg;
   assign Read_Data_out  = rd_reg;
   assign ALU_Result_out = alu_reg;
   assign Write_Reg_out  = wr_reg;
   assign misalign_out   = mis_reg;
   assign bus_err_out    = berr_reg;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios then random instructions, each
// checked against a transaction-level model of the stage's visible results.
module tb_mem_access_ctrl;
   localparam int TO = 16;

   logic        clk;
   logic        reset_in;
   logic        RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in;
   logic [31:0] ALU_Result_in, RT_data_in;
   logic [4:0]  Write_Reg_in;
   logic        stall_out, RegWrite_out, MemtoReg_out;
   logic [31:0] Read_Data_out, ALU_Result_out;
   logic [4:0]  Write_Reg_out;
   logic        misalign_out, bus_err_out;

   int total = 0;
   int bad   = 0;

   // Model of the MEM/WB registers as last written by a completed event.
   logic        m_rw, m_m2r;
   logic [31:0] m_alu, m_rd;
   logic [4:0]  m_wr;

   mem_access_ctrl_if #(.n(32)) bus ();

   mem_access_ctrl #(.n(32), .TIMEOUT(TO)) dut (
      .clk(clk), .reset_in(reset_in),
      .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
      .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
      .ALU_Result_in(ALU_Result_in), .RT_data_in(RT_data_in),
      .Write_Reg_in(Write_Reg_in), .mem(bus),
      .stall_out(stall_out), .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
      .Read_Data_out(Read_Data_out), .ALU_Result_out(ALU_Result_out),
      .Write_Reg_out(Write_Reg_out), .misalign_out(misalign_out), .bus_err_out(bus_err_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected finish before 500000ns");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag, input logic st, input logic rq,
                            input logic mis, input logic berr);
      chk({tag, ".stall"},    32'(stall_out),    32'(st));
      chk({tag, ".req"},      32'(bus.dmem_req), 32'(rq));
      chk({tag, ".misalign"}, 32'(misalign_out), 32'(mis));
      chk({tag, ".bus_err"},  32'(bus_err_out),  32'(berr));
      chk({tag, ".RegWrite"}, 32'(RegWrite_out), 32'(m_rw));
      chk({tag, ".MemtoReg"}, 32'(MemtoReg_out), 32'(m_m2r));
      chk({tag, ".ALU"},      ALU_Result_out,    m_alu);
      chk({tag, ".Read"},     Read_Data_out,     m_rd);
      chk({tag, ".WReg"},     32'(Write_Reg_out), 32'(m_wr));
   endtask

   task automatic chk_bus(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic w);
      chk({tag, ".addr"},  bus.dmem_addr,  a);
      chk({tag, ".wdata"}, bus.dmem_wdata, d);
      chk({tag, ".we"},    32'(bus.dmem_we), 32'(w));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // delay = ACCESS cycle whose closing edge samples ack; 0 or > TO means no ack.
   task automatic run_instr(input string tag, input logic rw, input logic m2r,
                            input logic mr, input logic mw, input logic [31:0] alu,
                            input logic [31:0] rt, input logic [4:0] wr,
                            input int delay, input logic [31:0] rdat);
      int n_cyc;
      bit acked;
      RegWrite_in = rw; MemtoReg_in = m2r; MemRead_in = mr; MemWrite_in = mw;
      ALU_Result_in = alu; RT_data_in = rt; Write_Reg_in = wr;
      bus.dmem_ack = 1'b0;
      tick();
      if (!mr && !mw) begin
         m_rw = rw; m_m2r = m2r; m_alu = alu; m_wr = wr; m_rd = 32'h0;
         chk_state({tag, ".alu"}, 1'b0, 1'b0, 1'b0, 1'b0);
         $display("txn %s: alu-op result=%h reg=%0d", tag, alu, wr);
      end else if (alu[1:0] != 2'b00) begin
         m_rw = 1'b0;
         chk_state({tag, ".mis"}, 1'b0, 1'b0, 1'b1, 1'b0);
         $display("txn %s: misaligned addr=%h", tag, alu);
      end else begin
         m_rw = 1'b0;
         chk_state({tag, ".req"}, 1'b1, 1'b1, 1'b0, 1'b0);
         chk_bus({tag, ".req"}, alu, rt, mw);
         acked = (delay >= 1 && delay <= TO);
         n_cyc = acked ? delay : TO;
         for (int c = 1; c <= n_cyc; c++) begin
            RegWrite_in = 1'($urandom); MemtoReg_in = 1'($urandom);
            MemRead_in = 1'($urandom); MemWrite_in = 1'($urandom);
            ALU_Result_in = $urandom; RT_data_in = $urandom; Write_Reg_in = 5'($urandom);
            bus.dmem_ack   = (acked && c == delay);
            bus.dmem_rdata = (acked && c == delay) ? rdat : $urandom;
            tick();
            bus.dmem_ack = 1'b0;
            if (c < n_cyc) begin
               chk({tag, ".hold_stall"}, 32'(stall_out), 32'h1);
               chk({tag, ".hold_req"}, 32'(bus.dmem_req), 32'h1);
               chk_bus({tag, ".hold"}, alu, rt, mw);
            end
         end
         if (acked) begin
            m_rw = rw; m_m2r = m2r; m_alu = alu; m_wr = wr; m_rd = mw ? 32'h0 : rdat;
         end
         chk_state({tag, ".done"}, 1'b0, 1'b0, 1'b0, !acked);
         $display("txn %s: %s addr=%h cycles=%0d %s", tag, mw ? "store" : "load", alu,
                  n_cyc, acked ? "acked" : "timeout");
      end
   endtask

   initial begin
      logic [31:0] a, d;
      int kind, dly;
      reset_in = 1'b0;
      RegWrite_in = 0; MemtoReg_in = 0; MemRead_in = 0; MemWrite_in = 0;
      ALU_Result_in = 0; RT_data_in = 0; Write_Reg_in = 0;
      bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0;
      m_rw = 0; m_m2r = 0; m_alu = 0; m_rd = 0; m_wr = 0;
      #2;
      chk_state("reset", 1'b0, 1'b0, 1'b0, 1'b0);
      chk_bus("reset", 32'h0, 32'h0, 1'b0);
      tick();
      tick();
      reset_in = 1'b1;

      run_instr("alu_op",     1, 0, 0, 0, 32'h9,  32'h0, 5'd5, 0, 32'h0);
      run_instr("load",       1, 1, 1, 0, 32'h10, 32'h77, 5'd7, 3, 32'hDEADBEEF);
      run_instr("after_load", 1, 0, 0, 0, 32'h1234, 32'h0, 5'd2, 0, 32'h0);
      run_instr("store",      0, 0, 0, 1, 32'h20, 32'h3, 5'd0, 2, 32'hFFFF0000);
      run_instr("misalign",   1, 1, 1, 0, 32'h22, 32'h0, 5'd9, 0, 32'h0);
      run_instr("after_mis",  0, 0, 0, 0, 32'h5, 32'h0, 5'd1, 0, 32'h0);
      run_instr("timeout",    1, 1, 1, 0, 32'h40, 32'h0, 5'd3, 0, 32'h0);
      run_instr("after_to",   1, 0, 0, 0, 32'h6, 32'h0, 5'd4, 0, 32'h0);
      run_instr("ack_at_to",  1, 1, 1, 0, 32'h44, 32'h0, 5'd6, TO, 32'hCAFEF00D);
      run_instr("both_rw",    1, 1, 1, 1, 32'h48, 32'hABCD, 5'd8, 1, 32'h11111111);

      // An ack arriving while idle must not disturb a plain ALU result.
      RegWrite_in = 1; MemtoReg_in = 0; MemRead_in = 0; MemWrite_in = 0;
      ALU_Result_in = 32'h77; Write_Reg_in = 5'd12;
      bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h55555555;
      tick();
      bus.dmem_ack = 1'b0;
      m_rw = 1; m_m2r = 0; m_alu = 32'h77; m_wr = 5'd12; m_rd = 32'h0;
      chk_state("idle_ack", 1'b0, 1'b0, 1'b0, 1'b0);
      $display("txn idle_ack: ack in IDLE ignored");

      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 4);
         a = $urandom;
         d = $urandom;
         dly = $urandom_range(1, TO + 2);
         if (kind == 1) a[1:0] = 2'($urandom_range(1, 3));
         else           a[1:0] = 2'b00;
         case (kind)
            0: run_instr("rnd", 1'($urandom), 1'($urandom), 0, 0, a, d, 5'($urandom), 0, 32'h0);
            1: run_instr("rnd", 1'($urandom), 1'($urandom), 1'($urandom_range(0, 1)), 1,
                         a, d, 5'($urandom), 0, 32'h0);
            2: run_instr("rnd", 1'($urandom), 1'($urandom), 1, 0, a, d, 5'($urandom), dly, $urandom);
            3: run_instr("rnd", 1'($urandom), 1'($urandom), 0, 1, a, d, 5'($urandom), dly, $urandom);
            default: run_instr("rnd", 1'($urandom), 1'($urandom), 1, 1, a, d, 5'($urandom), dly,
                               $urandom);
         endcase
      end

      // Reset in the middle of an access, then a late ack after release.
      RegWrite_in = 1; MemtoReg_in = 1; MemRead_in = 1; MemWrite_in = 0;
      ALU_Result_in = 32'h80; RT_data_in = 32'h0; Write_Reg_in = 5'd3;
      tick();
      chk("mid_rst.req_before", 32'(bus.dmem_req), 32'h1);
      tick();
      #2;
      reset_in = 1'b0;
      #1;
      m_rw = 0; m_m2r = 0; m_alu = 0; m_rd = 0; m_wr = 0;
      chk_state("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0);
      chk_bus("mid_rst", 32'h0, 32'h0, 1'b0);
      RegWrite_in = 0; MemtoReg_in = 0; MemRead_in = 0; MemWrite_in = 0;
      ALU_Result_in = 0; RT_data_in = 0; Write_Reg_in = 0;
      @(negedge clk);
      reset_in = 1'b1;
      bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hBADBAD00;
      tick();
      bus.dmem_ack = 1'b0;
      chk_state("late_ack", 1'b0, 1'b0, 1'b0, 1'b0);
      $display("txn mid_rst: reset during access, late ack ignored");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
